// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit feeding the HI/LO registers.
// One shift-add (multiply) or restoring (divide) step per cycle, WIDTH steps
// per operation. HI/LO also accept direct writes (MTHI/MTLO) when not busy.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting; MTHI/MTLO accepted, start latches operands
// RUN   | iterating on working registers; HI/LO hold previous values
// FIN   | one-cycle done pulse; behaves like IDLE for start/MTHI/MTLO
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;

  // Latched operation context
  logic             is_div;
  logic             neg_q;   // negate product / quotient
  logic             neg_r;   // negate remainder (dividend was negative)
  logic             dvz;     // divisor was zero
  logic [WIDTH-1:0] a_raw;   // original dividend, returned on divide by zero
  logic [WIDTH-1:0] opnd;    // multiplicand or divisor magnitude

  // Working registers, separate from the architectural HI/LO
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;

  // Operand magnitudes at start
  logic             a_sgn, b_sgn;
  logic [WIDTH-1:0] a_mag, b_mag;

  // One iteration and final result
  logic [WIDTH:0]     shifted, diff, sum;
  logic               ge;
  logic [WIDTH:0]     hi_nxt;
  logic [WIDTH-1:0]   lo_nxt;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // Signed ops take two's-complement magnitudes; unsigned ops pass through
  always_comb begin
    a_sgn = ~op[0] & A[WIDTH-1];
    b_sgn = ~op[0] & B[WIDTH-1];
    a_mag = a_sgn ? (-A) : A;
    b_mag = b_sgn ? (-B) : B;
  end

  // Single multiply or divide step on the working registers, plus final fix-up
  always_comb begin
    shifted = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd});
    diff    = shifted - {1'b0, opnd};
    sum     = acc_hi + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};
    if (is_div) begin
      hi_nxt = ge ? diff : shifted;
      lo_nxt = {acc_lo[WIDTH-2:0], ge};
    end else begin
      hi_nxt = {1'b0, sum[WIDTH:1]};
      lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
    end
    prod   = {hi_nxt[WIDTH-1:0], lo_nxt};
    prod_s = neg_q ? (-prod) : prod;
    if (is_div) begin
      if (dvz) begin
        res_lo = {WIDTH{1'b1}};
        res_hi = a_raw;
      end else begin
        res_lo = neg_q ? (-lo_nxt) : lo_nxt;
        res_hi = neg_r ? (-hi_nxt[WIDTH-1:0]) : hi_nxt[WIDTH-1:0];
      end
    end else begin
      res_hi = prod_s[2*WIDTH-1:WIDTH];
      res_lo = prod_s[WIDTH-1:0];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: state_nxt = start ? RUN : IDLE;
      RUN:       state_nxt = (cnt == LAST) ? FIN : RUN;
      default:   state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state == RUN);
    done = (state == FIN);
  end

  // Datapath: operand latch, iteration, HI/LO update
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      HI     <= '0;
      LO     <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dvz    <= 1'b0;
      a_raw  <= '0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else if (state == RUN) begin
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
      if (cnt == LAST) begin
        cnt <= '0;
        HI  <= res_hi;
        LO  <= res_lo;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      if (hi_wr) HI <= wdata;
      if (lo_wr) LO <= wdata;
      if (start) begin
        cnt    <= '0;
        is_div <= op[1];
        neg_q  <= a_sgn ^ b_sgn;
        neg_r  <= a_sgn;
        dvz    <= (B == '0);
        a_raw  <= A;
        opnd   <= op[1] ? b_mag : a_mag;
        acc_hi <= '0;
        acc_lo <= op[1] ? a_mag : b_mag;
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit that sits directly downstream of the general-purpose register file.
- Consumes the two register read ports A and B, and executes MULT, MULTU, DIV and DIVU into the architectural HI/LO registers.
- Also services MTHI/MTLO writes.
- Exposes HI/LO for MFHI/MFLO, plus busy/done so the control FSM can stall.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin the operation selected by op with the current A/B.
- op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU.
- A  input  WIDTH  rs operand from the register file; multiplicand or dividend.
- B  input  WIDTH  rt operand from the register file; multiplier or divisor.
- hi_wr  input  1  MTHI: HI <= wdata.
- lo_wr  input  1  MTLO: LO <= wdata.
- wdata  input  WIDTH  data for MTHI/MTLO.
- busy  output  1  high while an operation is iterating.
- done  output  1  one-cycle pulse when HI/LO hold a new result.
- HI  output  WIDTH  HI register: product upper word, or remainder.
- LO  output  WIDTH  LO register: product lower word, or quotient.

Behaviour:

Reset:
- rst high at a posedge forces state=IDLE, HI=0, LO=0, busy=0, done=0, and clears the iteration counter.
- rst overrides every other input.
- Reset mid-operation aborts the operation; HI/LO are not updated with a partial result.

FSM states: IDLE, RUN, FIN.
- IDLE: busy=0, done=0. If start=1, latch op, A and B at that edge (E0) and go to RUN with the counter at 0.
- RUN: busy=1, done=0. Perform one iteration per cycle and increment the counter. At the edge where the counter reaches WIDTH-1 (edge E32 for the default), write the final HI/LO and go to FIN.
- FIN: busy=0, done=1 for exactly one cycle. If start=1, behave as in IDLE (latch operands and enter RUN); otherwise go to IDLE.

Latency and operands:
- start sampled at E0 -> busy high for 32 cycles -> HI/LO valid and done=1 after E32.
- Operands are latched at E0; later changes on A/B have no effect.
- start while in RUN is ignored and is not queued.

Multiply:
- Shift-add on operand magnitudes giving a 2*WIDTH product; HI=upper word, LO=lower word.
- MULT: magnitudes come from two's complement, and the product is negated when sign(A) XOR sign(B) is set.
- MULTU: operands are treated as unsigned. Neither multiply raises an exception.

Divide:
- Restoring division on magnitudes; LO=quotient, HI=remainder.
- DIV: the quotient is negated when the signs differ, and the remainder takes the sign of the dividend.
- DIV of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0. This is the natural magnitude result; no flag is raised.
- Divide by zero (B=0), for both DIV and DIVU, overrides the result: LO=0xFFFFFFFF, HI=latched A. It still takes the full 32 cycles.

MTHI/MTLO:
- hi_wr/lo_wr update HI/LO at the edge in IDLE or FIN.
- In RUN they are ignored.
- hi_wr and lo_wr may be asserted together.
- hi_wr/lo_wr together with start in IDLE/FIN: the write takes effect at E0 and the operation starts; the result at E32 overwrites HI/LO.

Outputs:
- HI/LO are registered outputs.
- During RUN they hold their pre-operation values, and the internal working registers are separate.
- Intermediate accumulator widths are WIDTH+1 for divide and 2*WIDTH for multiply; no truncation before the final write.

Test Plan:
- rst for 2 cycles, then MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> busy high exactly 32 cycles, done pulse 1 cycle, HI=0xFFFFFFFE LO=0x00000001.
- MULT A=0xFFFFFFFD (-3) B=7 -> HI=0xFFFFFFFF LO=0xFFFFFFEB; then MULT with A=0x80000000 and B=0x80000000 -> HI=0x40000000 LO=0.
- DIV A=0xFFFFFFF9 (-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with the same operands -> LO=0x7FFFFFFC, HI=1.
- DIVU A=0x1234 B=0 -> LO=0xFFFFFFFF HI=0x1234. DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000 HI=0.
- Start MULTU 3x5; at RUN cycle 10 pulse start with new operands, toggle A/B, and assert hi_wr -> all ignored, final HI=0 LO=15. In FIN assert start (DIVU 100/7) -> back-to-back run gives LO=14 HI=2.
- MTHI 0xAAAA, then start MULTU and assert rst at RUN cycle 16 -> HI=LO=0, busy=0, done never pulses. After reset, MTLO 0x55 in IDLE -> LO=0x55 the next cycle.
